arb_byte_packetizer: RTL and testbench

Downstream stage of the round-robin FIFO arbiter. Accepts the arbiter's byte stream (dout/valid, no backpressure) into an internal elastic buffer. Emits framed packets on a ready/valid byte interface: header byte, PAYLOAD_LEN payload bytes, then a checksum byte. Any byte that arrives while the buffer is full is dropped and flagged.

---
 rtl/arb_byte_packetizer.sv | 151 +++++++++++++++
 tb/tb_arb_byte_packetizer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_byte_packetizer.sv
// Packetizer behind the round-robin arbiter: buffers the unthrottled byte stream and
// frames it as header / PAYLOAD_LEN payload bytes / checksum on a ready/valid output.
module arb_byte_packetizer #(
  parameter int          PAYLOAD_LEN = 4,
  parameter int          DEPTH       = 16,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               din,
  input  logic                     din_valid,
  output logic [7:0]               pkt_byte,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic                     pkt_sop,
  output logic                     pkt_eop,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_W   = PAYLOAD_LEN[AW:0];
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;

  state_t          r_state, w_stateNext;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_head, r_tail;
  logic [AW:0]     r_fill, r_idx;
  logic [7:0]      r_sum, r_byte;
  logic            r_valid, r_sop, r_eop, r_overflow;

  logic            w_xfer, w_full, w_push, w_pop, w_drop;
  logic [7:0]      w_headByte, w_byteNext, w_sumNext;
  logic            w_validNext, w_sopNext, w_eopNext;
  logic [AW:0]     w_idxNext;

  assign w_xfer     = r_valid & pkt_ready;
  assign w_full     = (r_fill == DEPTH_W);
  assign w_headByte = r_mem[r_head];
  // A full buffer still accepts a byte when the same edge frees a slot.
  assign w_push     = din_valid & (~w_full | w_pop);
  assign w_drop     = din_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (r_fill >= LEN_W) w_stateNext = HDR;
      HDR:     if (w_xfer) w_stateNext = PAY;
      PAY:     if (w_xfer && r_idx == LEN_W) w_stateNext = CHK;
      CHK:     if (w_xfer) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_byteNext  = r_byte;
    w_validNext = r_valid;
    w_sopNext   = r_sop;
    w_eopNext   = r_eop;
    w_sumNext   = r_sum;
    w_idxNext   = r_idx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        // Waiting for a whole payload reserves it, so later pops never underflow.
        if (r_fill >= LEN_W) begin
          w_byteNext  = HEADER;
          w_validNext = 1'b1;
          w_sopNext   = 1'b1;
          w_eopNext   = 1'b0;
          w_sumNext   = 8'h00;
        end
      end
      HDR: begin
        if (w_xfer) begin
          w_pop      = 1'b1;
          w_byteNext = w_headByte;
          w_sopNext  = 1'b0;
          w_sumNext  = w_headByte;
          w_idxNext  = (AW+1)'(1);
        end
      end
      PAY: begin
        if (w_xfer) begin
          if (r_idx < LEN_W) begin
            w_pop      = 1'b1;
            w_byteNext = w_headByte;
            w_sumNext  = r_sum + w_headByte;
            w_idxNext  = r_idx + (AW+1)'(1);
          end else begin
            w_byteNext = r_sum;
            w_eopNext  = 1'b1;
          end
        end
      end
      CHK: begin
        if (w_xfer) begin
          w_validNext = 1'b0;
          w_eopNext   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte     <= 8'h00;
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_sum      <= 8'h00;
      r_idx      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_byte  <= w_byteNext;
      r_valid <= w_validNext;
      r_sop   <= w_sopNext;
      r_eop   <= w_eopNext;
      r_sum   <= w_sumNext;
      r_idx   <= w_idxNext;
      if (w_pop)  r_head <= r_head + AW'(1);
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + (AW+1)'(1);
      else if (!w_push && w_pop) r_fill <= r_fill - (AW+1)'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= din;
  end

  assign pkt_byte   = r_byte;
  assign pkt_valid  = r_valid;
  assign pkt_sop    = r_sop;
  assign pkt_eop    = r_eop;
  assign overflow   = r_overflow;
  assign fill_level = r_fill;

endmodule

// File: tb/tb_arb_byte_packetizer.sv
// Directed bench for arb_byte_packetizer: a vector table for framing, checksum wrap and
// backpressure, plus hand sequences for overflow, push/pop at full and mid-packet reset.
module tb_arb_byte_packetizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] pkt_byte;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       pkt_sop;
  logic       pkt_eop;
  logic       overflow;
  logic [4:0] fill_level;

  int checks = 0;
  int failures = 0;

  arb_byte_packetizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .pkt_byte   (pkt_byte),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_sop    (pkt_sop),
    .pkt_eop    (pkt_eop),
    .overflow   (overflow),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstN;
    logic [7:0] din;
    logic       dv;
    logic       rdy;
    logic       chkByte;
    logic [7:0] expByte;
    logic       expValid;
    logic       expSop;
    logic       expEop;
    logic       expOvf;
    logic [4:0] expFill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [7:0] d, logic dv, logic rdy, logic cb,
                              logic [7:0] eb, logic ev, logic es, logic ee, logic eo,
                              logic [4:0] ef);
    vec_t v;
    v.rstN = r; v.din = d; v.dv = dv; v.rdy = rdy; v.chkByte = cb;
    v.expByte = eb; v.expValid = ev; v.expSop = es; v.expEop = ee;
    v.expOvf = eo; v.expFill = ef;
    return v;
  endfunction

  function automatic void addPush(logic [7:0] d, logic rdy, logic [4:0] f);
    vecs.push_back(mk(1'b1, d, 1'b1, rdy, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, f));
  endfunction

  function automatic void addOut(logic [7:0] b, logic s, logic e, logic rdy, logic [4:0] f);
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, rdy, 1'b1, b, 1'b1, s, e, 1'b0, f));
  endfunction

  function automatic void addGap(logic [4:0] f);
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, f));
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic driveIn(input logic r, input logic [7:0] d, input logic dv, input logic rdy);
    rst_n = r; din = d; din_valid = dv; pkt_ready = rdy;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveIn(v.rstN, v.din, v.dv, v.rdy);
    stepEdge();
  endtask

  task automatic checkOutput(input int i, input vec_t v);
    if (v.chkByte) checkVal($sformatf("vec%0d.byte", i), 32'(pkt_byte), 32'(v.expByte));
    checkVal($sformatf("vec%0d.valid", i), 32'(pkt_valid), 32'(v.expValid));
    checkVal($sformatf("vec%0d.sop", i), 32'(pkt_sop), 32'(v.expSop));
    checkVal($sformatf("vec%0d.eop", i), 32'(pkt_eop), 32'(v.expEop));
    checkVal($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(v.expOvf));
    checkVal($sformatf("vec%0d.fill", i), 32'(fill_level), 32'(v.expFill));
  endtask

  // Expects pkt_ready already held at 1; waits a bounded time for the header.
  task automatic receivePacket(input string name, input logic [31:0] pay);
    logic [7:0] sum;
    int t;
    sum = pay[31:24] + pay[23:16] + pay[15:8] + pay[7:0];
    t = 0;
    while (!(pkt_valid && pkt_sop) && t < 12) begin
      stepEdge();
      t++;
    end
    checkVal({name, ".hdrSeen"}, 32'(pkt_valid && pkt_sop), 32'd1);
    checkVal({name, ".hdr"}, 32'(pkt_byte), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      stepEdge();
      checkVal($sformatf("%s.pay%0d", name, i), 32'(pkt_byte), 32'(pay[31-8*i -: 8]));
      checkVal($sformatf("%s.flags%0d", name, i), {29'd0, pkt_valid, pkt_sop, pkt_eop}, 32'b100);
    end
    stepEdge();
    checkVal({name, ".sum"}, 32'(pkt_byte), 32'(sum));
    checkVal({name, ".eop"}, {29'd0, pkt_valid, pkt_sop, pkt_eop}, 32'b101);
    stepEdge();
    checkVal({name, ".gap"}, 32'(pkt_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    driveIn(1'b0, 8'h00, 1'b0, 1'b1);

    // Basic framing 01..04 -> checksum 0A.
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0));
    addPush(8'h01, 1, 1); addPush(8'h02, 1, 2); addPush(8'h03, 1, 3); addPush(8'h04, 1, 4);
    addOut(8'hA5, 1, 0, 1, 4);
    addOut(8'h01, 0, 0, 1, 3); addOut(8'h02, 0, 0, 1, 2);
    addOut(8'h03, 0, 0, 1, 1); addOut(8'h04, 0, 0, 1, 0);
    addOut(8'h0A, 0, 1, 1, 0); addGap(0);
    // Checksum wrap FF,FF,02,01 -> 01.
    addPush(8'hFF, 1, 1); addPush(8'hFF, 1, 2); addPush(8'h02, 1, 3); addPush(8'h01, 1, 4);
    addOut(8'hA5, 1, 0, 1, 4);
    addOut(8'hFF, 0, 0, 1, 3); addOut(8'hFF, 0, 0, 1, 2);
    addOut(8'h02, 0, 0, 1, 1); addOut(8'h01, 0, 0, 1, 0);
    addOut(8'h01, 0, 1, 1, 0); addGap(0);
    // 80,80,00,00 -> 00.
    addPush(8'h80, 1, 1); addPush(8'h80, 1, 2); addPush(8'h00, 1, 3); addPush(8'h00, 1, 4);
    addOut(8'hA5, 1, 0, 1, 4);
    addOut(8'h80, 0, 0, 1, 3); addOut(8'h80, 0, 0, 1, 2);
    addOut(8'h00, 0, 0, 1, 1); addOut(8'h00, 0, 0, 1, 0);
    addOut(8'h00, 0, 1, 1, 0); addGap(0);
    // Backpressure on the header for three edges.
    addPush(8'h01, 0, 1); addPush(8'h02, 0, 2); addPush(8'h03, 0, 3); addPush(8'h04, 0, 4);
    addOut(8'hA5, 1, 0, 0, 4);
    addOut(8'hA5, 1, 0, 0, 4); addOut(8'hA5, 1, 0, 0, 4); addOut(8'hA5, 1, 0, 0, 4);
    addOut(8'h01, 0, 0, 1, 3); addOut(8'h02, 0, 0, 1, 2);
    addOut(8'h03, 0, 0, 1, 1); addOut(8'h04, 0, 0, 1, 0);
    addOut(8'h0A, 0, 1, 1, 0); addGap(0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Overflow: 17 pushes with the consumer stalled; byte 10 must be dropped.
    driveIn(1'b0, 8'h00, 1'b0, 1'b0);
    stepEdge();
    for (int i = 0; i < 17; i++) begin
      driveIn(1'b1, 8'(i), 1'b1, 1'b0);
      stepEdge();
      checkVal($sformatf("ovf.fill%0d", i), 32'(fill_level), (i < 16) ? 32'(i + 1) : 32'd16);
      checkVal($sformatf("ovf.flag%0d", i), 32'(overflow), (i == 16) ? 32'd1 : 32'd0);
    end
    driveIn(1'b1, 8'h00, 1'b0, 1'b1);
    receivePacket("ovf.p0", 32'h00010203);
    receivePacket("ovf.p1", 32'h04050607);
    receivePacket("ovf.p2", 32'h08090A0B);
    receivePacket("ovf.p3", 32'h0C0D0E0F);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      stepEdge();
      if (pkt_valid) seen++;
    end
    checkVal("ovf.noExtra", 32'(seen), 32'd0);
    checkVal("ovf.fillEnd", 32'(fill_level), 32'd0);
    checkVal("ovf.sticky", 32'(overflow), 32'd1);

    // Push and pop on the same edge while full in PAY.
    driveIn(1'b0, 8'h00, 1'b0, 1'b0);
    stepEdge();
    for (int i = 0; i < 4; i++) begin
      driveIn(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
      stepEdge();
    end
    driveIn(1'b1, 8'h00, 1'b0, 1'b0);
    stepEdge();
    checkVal("pp.hdr", 32'(pkt_byte), 32'hA5);
    driveIn(1'b1, 8'h24, 1'b1, 1'b1);
    stepEdge();
    checkVal("pp.b0", 32'(pkt_byte), 32'h20);
    checkVal("pp.fill4", 32'(fill_level), 32'd4);
    for (int i = 0; i < 12; i++) begin
      driveIn(1'b1, 8'h25 + 8'(i), 1'b1, 1'b0);
      stepEdge();
    end
    checkVal("pp.full", 32'(fill_level), 32'd16);
    checkVal("pp.hold", 32'(pkt_byte), 32'h20);
    driveIn(1'b1, 8'h31, 1'b1, 1'b1);
    stepEdge();
    checkVal("pp.b1", 32'(pkt_byte), 32'h21);
    checkVal("pp.fillSame", 32'(fill_level), 32'd16);
    checkVal("pp.noOvf", 32'(overflow), 32'd0);
    driveIn(1'b1, 8'h00, 1'b0, 1'b1);
    stepEdge();
    checkVal("pp.b2", 32'(pkt_byte), 32'h22);
    checkVal("pp.fill15", 32'(fill_level), 32'd15);
    stepEdge();
    checkVal("pp.b3", 32'(pkt_byte), 32'h23);
    stepEdge();
    checkVal("pp.sum", 32'(pkt_byte), 32'h86);
    checkVal("pp.eop", 32'(pkt_eop), 32'd1);
    stepEdge();
    checkVal("pp.gap", 32'(pkt_valid), 32'd0);
    receivePacket("pp.next", 32'h24252627);

    // Reset in the middle of a packet.
    driveIn(1'b0, 8'h00, 1'b0, 1'b1);
    stepEdge();
    for (int i = 0; i < 4; i++) begin
      driveIn(1'b1, 8'h01 + 8'(i), 1'b1, 1'b1);
      stepEdge();
    end
    driveIn(1'b1, 8'h00, 1'b0, 1'b1);
    stepEdge();
    stepEdge();
    stepEdge();
    checkVal("rst.pre", 32'(pkt_byte), 32'h02);
    stepEdge();
    driveIn(1'b0, 8'h00, 1'b0, 1'b1);
    stepEdge();
    checkVal("rst.byte", 32'(pkt_byte), 32'h00);
    checkVal("rst.flags", {28'd0, pkt_valid, pkt_sop, pkt_eop, overflow}, 32'd0);
    checkVal("rst.fill", 32'(fill_level), 32'd0);
    for (int i = 0; i < 4; i++) begin
      driveIn(1'b1, 8'h05 + 8'(i), 1'b1, 1'b1);
      stepEdge();
    end
    driveIn(1'b1, 8'h00, 1'b0, 1'b1);
    receivePacket("rst.pkt", 32'h05060708);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
